freq_meas_ctrl: RTL and testbench

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

---
 rtl/freq_meas_pkg.sv | 25 ++
 rtl/edge_det_rise.sv | 30 +++
 rtl/freq_meas_ctrl.sv | 163 ++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// ============================================================================
// Module      : freq_meas_pkg
// Description : Shared state encoding and default constants for freq_meas_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package freq_meas_pkg;

  localparam int unsigned DEF_PERIOD_W    = 13;
  localparam int unsigned DEF_AVG_LOG2    = 2;
  localparam int unsigned DEF_SETTLE_CYC  = 256;
  localparam int unsigned DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACQ    = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_det_rise.sv
// ============================================================================
// Module      : edge_det_rise
// Description : Rising-edge detector; pulse is high while sig is high and was low last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module edge_det_rise (
  input  logic adc_clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic r_sig_d;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= sig;
    end
  end

  assign pulse = sig & ~r_sig_d;

endmodule

`default_nettype wire

// File: rtl/freq_meas_ctrl.sv
// ============================================================================
// Module      : freq_meas_ctrl
// Description : Settles the frequency detector, averages N period samples, reports with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned PERIOD_W    = DEF_PERIOD_W,
  parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                adc_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                det_en,
  input  logic [PERIOD_W-1:0] det_period,
  output logic                det_stable,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [PERIOD_W-1:0] period_avg
);

  localparam int unsigned c_ACC_W = PERIOD_W + AVG_LOG2;
  localparam int unsigned c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned c_TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned c_NS_W  = AVG_LOG2 + 1;

  localparam logic [c_SET_W-1:0] c_SETTLE_LOAD = c_SET_W'(SETTLE_CYC - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST    = c_TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_NS_W-1:0]  c_LAST_SAMPLE = c_NS_W'((1 << AVG_LOG2) - 1);

  state_t               r_state;
  state_t               w_next;
  logic [c_SET_W-1:0]   r_settle_cnt;
  logic [c_TMO_W-1:0]   r_acq_cnt;
  logic [c_NS_W-1:0]    r_nsamp;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_ACC_W-1:0]   w_acc_next;
  logic [PERIOD_W-1:0]  w_avg_next;
  logic                 w_pulse;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_tmo_hit;
  logic                 w_start_acc;
  logic                 w_avg_load;
  logic                 w_set_tmo;

  edge_det_rise u_edge_det (
    .adc_clk (adc_clk),
    .rst_n   (rst_n),
    .sig     (det_en),
    .pulse   (w_pulse)
  );

  // Zero-period samples are detector misfires and are dropped entirely.
  assign w_accept   = (r_state == ST_ACQ) && w_pulse && (det_period != '0);
  assign w_last     = w_accept && (r_nsamp == c_LAST_SAMPLE);
  assign w_tmo_hit  = (r_acq_cnt == c_TMO_LAST);
  assign w_acc_next = r_acc + c_ACC_W'(det_period);
  assign w_avg_next = PERIOD_W'(w_acc_next >> AVG_LOG2);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_avg_load  = 1'b0;
    w_set_tmo   = 1'b0;
    det_stable  = 1'b0;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next      = ST_SETTLE;
            w_start_acc = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            w_next = ST_ACQ;
          end
        end
        ST_ACQ: begin
          // A final sample landing on the timeout cycle still counts as success.
          if (w_last) begin
            w_next     = ST_FIN;
            w_avg_load = 1'b1;
          end else if (w_tmo_hit) begin
            w_next    = ST_FIN;
            w_set_tmo = 1'b1;
          end
        end
        ST_FIN: begin
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
    if (r_state == ST_ACQ) begin
      det_stable = 1'b1;
    end
    if (r_state == ST_FIN) begin
      done = 1'b1;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_acq_cnt    <= '0;
      r_nsamp      <= '0;
      r_acc        <= '0;
      timeout      <= 1'b0;
      period_avg   <= '0;
    end else begin
      if (w_start_acc) begin
        r_settle_cnt <= c_SETTLE_LOAD;
        r_acq_cnt    <= '0;
        r_nsamp      <= '0;
        r_acc        <= '0;
        timeout      <= 1'b0;
      end
      if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - c_SET_W'(1);
      end
      if (r_state == ST_ACQ) begin
        r_acq_cnt <= r_acq_cnt + c_TMO_W'(1);
        if (w_accept) begin
          r_acc   <= w_acc_next;
          r_nsamp <= r_nsamp + c_NS_W'(1);
        end
      end
      if (w_avg_load) begin
        period_avg <= w_avg_next;
      end
      if (w_set_tmo) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_freq_meas_ctrl.sv
// ============================================================================
// Module      : tb_freq_meas_ctrl
// Description : Scoreboard bench for freq_meas_ctrl with directed period vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_meas_ctrl;

  localparam int PW = 13;
  localparam int SC = 256;
  localparam int TC = 1000;

  logic          adc_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          det_en;
  logic [PW-1:0] det_period;
  logic          det_stable;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [PW-1:0] period_avg;

  freq_meas_ctrl #(
    .PERIOD_W    (PW),
    .AVG_LOG2    (2),
    .SETTLE_CYC  (SC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .det_en     (det_en),
    .det_period (det_period),
    .det_stable (det_stable),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .period_avg (period_avg)
  );

  always #5 adc_clk = ~adc_clk;

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PW-1:0] avg;
    logic          tmo;
    logic [31:0]   cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge adc_clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("period_avg", {19'd0, period_avg}, {19'd0, e.avg});
        chk("timeout_flag", {31'd0, timeout}, {31'd0, e.tmo});
        chk("stable_in_fin", {31'd0, det_stable}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic expect_done(input logic [PW-1:0] avg, input logic tmo, input int dc);
    exp_t e;
    e.avg = avg;
    e.tmo = tmo;
    e.cyc = dc;
    sb.push_back(e);
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s     = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_stable(input int s, output int a);
    int n;
    n = 0;
    do begin
      @(negedge adc_clk);
      n++;
    end while (det_stable !== 1'b1 && n < 400);
    chk("stable_rise_cycle", cyc, s + SC + 1);
    a = cyc;
    step();
  endtask

  task automatic pulse(input logic [PW-1:0] p);
    det_period = p;
    det_en     = 1'b1;
    step();
    det_en     = 1'b0;
    step();
  endtask

  task automatic last_pulse(input logic [PW-1:0] p, input logic [PW-1:0] avg);
    expect_done(avg, 1'b0, cyc + 1);
    pulse(p);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int a;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    det_en     = 1'b0;
    det_period = '0;
    step(); step(); step();
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_timeout",    {31'd0, timeout},    32'd0);
    chk("rst_det_stable", {31'd0, det_stable}, 32'd0);
    chk("rst_period_avg", {19'd0, period_avg}, 32'd0);
    rst_n = 1'b1;
    step();

    // Normal run: (1024+1024+1020+1028)/4 = 1024
    do_start(s);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_stable(s, a);
    pulse(13'd1024); pulse(13'd1024); pulse(13'd1020);
    last_pulse(13'd1028, 13'd1024);

    // Zero sample dropped: (512+513+513+513)>>2 = 2051>>2 = 512
    do_start(s);
    wait_stable(s, a);
    pulse(13'd512); pulse(13'd0); pulse(13'd513); pulse(13'd513);
    last_pulse(13'd513, 13'd512);

    // Timeout after TC cycles in ACQ with only three samples
    do_start(s);
    wait_stable(s, a);
    expect_done(13'd512, 1'b1, a + TC);
    pulse(13'd100); pulse(13'd200); pulse(13'd300);
    wait_idle();
    step(); step();
    chk("timeout_sticky", {31'd0, timeout}, 32'd1);
    chk("avg_kept_on_timeout", {19'd0, period_avg}, 32'd512);
    do_start(s);
    chk("timeout_cleared_by_start", {31'd0, timeout}, 32'd0);

    // Abort in SETTLE
    repeat (10) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_settle_busy",   {31'd0, busy},       32'd0);
    chk("abort_settle_stable", {31'd0, det_stable}, 32'd0);

    // Abort in ACQ after two samples
    do_start(s);
    wait_stable(s, a);
    pulse(13'd700); pulse(13'd700);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_acq_busy",   {31'd0, busy},       32'd0);
    chk("abort_acq_stable", {31'd0, det_stable}, 32'd0);
    chk("abort_acq_avg",    {19'd0, period_avg}, 32'd512);

    // Abort beats start
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    chk("abort_over_start", {31'd0, busy}, 32'd0);

    // Clean run after aborts: (2000+2000+2001+2003)>>2 = 8004>>2 = 2001
    do_start(s);
    wait_stable(s, a);
    pulse(13'd2000); pulse(13'd2000); pulse(13'd2001);
    last_pulse(13'd2003, 13'd2001);

    // Level held across ACQ entry, extra starts while busy
    do_start(s);
    repeat (5) step();
    det_period = 13'd4000;
    det_en     = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    wait_stable(s, a);
    repeat (3) step();
    det_en = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    pulse(13'd8); pulse(13'd8); pulse(13'd9);
    // Final sample 9: (8+8+9+9)>>2 = 34>>2 = 8; start during FIN is ignored
    expect_done(13'd8, 1'b0, cyc + 1);
    det_period = 13'd9;
    det_en     = 1'b1;
    step();
    det_en = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("fin_start_ignored", {31'd0, busy}, 32'd0);
    do_start(s);
    chk("start_after_done_accepted", {31'd0, busy}, 32'd1);
    wait_stable(s, a);
    pulse(13'd1500); pulse(13'd1500);

    // Asynchronous reset mid-ACQ
    rst_n = 1'b0;
    #1;
    chk("arst_busy",       {31'd0, busy},       32'd0);
    chk("arst_done",       {31'd0, done},       32'd0);
    chk("arst_timeout",    {31'd0, timeout},    32'd0);
    chk("arst_det_stable", {31'd0, det_stable}, 32'd0);
    chk("arst_period_avg", {19'd0, period_avg}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_resume_after_reset", {31'd0, busy}, 32'd0);
    do_start(s);
    wait_stable(s, a);
    pulse(13'd3000); pulse(13'd3000); pulse(13'd3000);
    last_pulse(13'd3000, 13'd3000);

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
